// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests, collects in-order
// memory responses into a small prefetch queue and hands them to decode.
// A redirect flushes the queue and silently drops every response that is
// still in flight at that point.
module fetch_unit #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h01000000),
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              req_valid_o,
  output logic [AWIDTH-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [DWIDTH-1:0] rsp_data_i,
  output logic              out_valid_o,
  output logic [AWIDTH-1:0] out_pc_o,
  output logic [DWIDTH-1:0] out_insn_o,
  input  logic              out_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]       DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] PC_STEP = AWIDTH'(4);

  logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [AWIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     p_q, p_d;
  logic [CW-1:0]     k_q, k_d;
  logic [CW-1:0]     q_q, q_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] insn_mem [DEPTH];

  logic              fire;
  logic              pop;
  logic              push;
  logic [CW-1:0]     p_next;
  logic [AWIDTH-1:0] redirect_tgt;

  // Issue is allowed only while every outstanding request has a guaranteed queue slot
  always_comb begin
    req_valid_o  = !rst && (({1'b0, p_q} + {1'b0, q_q}) < DEPTH_C);
    req_addr_o   = fetch_pc_q;
    out_valid_o  = (q_q != '0);
    out_pc_o     = pc_mem[rd_ptr_q];
    out_insn_o   = insn_mem[rd_ptr_q];
    redirect_tgt = {redirect_pc_i[AWIDTH-1:2], 2'b00};
  end

  // Next-state for PCs, counters and queue pointers; redirect overrides everything
  always_comb begin
    fire   = req_valid_o && req_ready_i;
    pop    = out_valid_o && out_ready_i;
    push   = rsp_valid_i && (k_q == '0) && !redirect_i;
    p_next = p_q + CW'(fire) - CW'(rsp_valid_i);

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    p_d        = p_next;
    k_d        = k_q;
    q_d        = q_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect_i) begin
      // Everything still in flight, including this cycle's handshake, gets dropped
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      k_d        = p_next;
      q_d        = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (rsp_valid_i && (k_q != '0)) begin
        k_d = k_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      q_d = q_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= BASEADDR;
      rsp_pc_q   <= BASEADDR;
      p_q        <= '0;
      k_q        <= '0;
      q_q        <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      p_q        <= p_d;
      k_q        <= k_d;
      q_q        <= q_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage is data only; validity is carried by the occupancy count
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
      insn_mem[wr_ptr_q] <= rsp_data_i;
    end
  end

  // A response with nothing outstanding means the memory side broke ordering
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_valid_i && (p_q == '0)));
    end
  end

endmodule
